muldiv_seq: RTL

Sequencing controller in front of the iterative multiply/divide unit of the rv32imac core. It accepts one M-extension operation at a time from the execute stage over a valid/ready handshake and drives the unit's instruction and operand inputs, holding them stable until the unit signals ready. It captures the result and returns it over a second valid/ready handshake. It also short-circuits divide-by-zero, rejects non-M opcodes, aborts on pipeline flush, and guards against a hung unit with a watchdog.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_rcache.sv | 35 +++
 rtl/muldiv_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension sequencing controller: state encoding,
// opcode codes, classification helpers and the cache entry layout.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Unit opcodes; MD_NOP idles the unit and re-arms its internal counter.
  localparam logic [7:0] MD_NOP      = 8'h00;
  localparam logic [7:0] INST_MUL    = 8'h01;
  localparam logic [7:0] INST_MULH   = 8'h02;
  localparam logic [7:0] INST_MULHSU = 8'h03;
  localparam logic [7:0] INST_MULHU  = 8'h04;
  localparam logic [7:0] INST_DIV    = 8'h05;
  localparam logic [7:0] INST_DIVU   = 8'h06;
  localparam logic [7:0] INST_REM    = 8'h07;
  localparam logic [7:0] INST_REMU   = 8'h08;

  localparam int TIMEOUT_CYC_DEF = 40;

  typedef struct packed {
    logic [7:0]  inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] result;
  } md_entry_t;

  function automatic logic is_muldiv(input logic [7:0] inst);
    return (inst >= INST_MUL) && (inst <= INST_REMU);
  endfunction

  function automatic logic is_div_class(input logic [7:0] inst);
    return (inst >= INST_DIV) && (inst <= INST_REMU);
  endfunction

endpackage

// File: rtl/muldiv_rcache.sv
// Single-entry result cache for muldiv_seq, built only when MULDIV_CACHE_EN is
// defined. Holds the last unit-computed {inst, rs1, rs2, result}.
module muldiv_rcache
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  lookup_inst,
  input  logic [31:0] lookup_rs1,
  input  logic [31:0] lookup_rs2,
  output logic        hit,
  output logic [31:0] hit_data,
  input  logic        store_en,
  input  md_entry_t   store_entry
);

  logic      valid_q;
  md_entry_t entry_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= 1'b0;
    else if (store_en) valid_q <= 1'b1;
  end

  // NOTE: the entry payload is deliberately not reset; valid_q alone gates its
  // use, so clearing the wide data register would only cost reset routing.
  always_ff @(posedge clk_i) begin
    if (store_en) entry_q <= store_entry;
  end

  assign hit = valid_q && (entry_q.inst == lookup_inst) &&
               (entry_q.rs1 == lookup_rs1) && (entry_q.rs2 == lookup_rs2);
  assign hit_data = entry_q.result;

endmodule

// File: rtl/muldiv_seq.sv
// Sequencing controller in front of the iterative mul/div unit: one request at
// a time, fast-path divide-by-zero, flush, watchdog. Optional MULDIV_CACHE_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TAG_W       = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [7:0]       req_inst_i,
  input  logic [31:0]      req_rs1_i,
  input  logic [31:0]      req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic [7:0]       md_inst_o,
  output logic [31:0]      md_rs1_o,
  output logic [31:0]      md_rs2_o,
  input  logic [31:0]      md_data_i,
  input  logic             md_ready_i,
  output logic             busy_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [7:0]       inst_q;
  logic [31:0]      rs1_q, rs2_q, data_q, data_d;
  logic [TAG_W-1:0] tag_q;
  logic             err_q, err_d;
  logic [WD_W-1:0]  wd_q;
  logic             accept, ld_req, set_rsp;
  logic             cache_hit;
  logic [31:0]      cache_data;

  assign req_ready_o = (state_q == ST_IDLE) && !rst_i && !flush_i;
  assign accept      = req_valid_i && req_ready_o;

`ifdef MULDIV_CACHE_EN
  logic store_en;
  assign store_en = (state_q == ST_BUSY) && md_ready_i && !flush_i;

  muldiv_rcache u_rcache (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lookup_inst (req_inst_i),
    .lookup_rs1  (req_rs1_i),
    .lookup_rs2  (req_rs2_i),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .store_en    (store_en),
    .store_entry ('{inst: inst_q, rs1: rs1_q, rs2: rs2_q, result: md_data_i})
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ld_req  = 1'b0;
    set_rsp = 1'b0;
    data_d  = data_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ld_req = 1'b1;
          if (!is_muldiv(req_inst_i)) begin
            state_d = ST_RESP; set_rsp = 1'b1; data_d = '0; err_d = 1'b1;
          end else if (is_div_class(req_inst_i) && (req_rs2_i == '0)) begin
            state_d = ST_RESP; set_rsp = 1'b1;
            data_d  = (req_inst_i == INST_DIV || req_inst_i == INST_DIVU) ? 32'hFFFF_FFFF
                                                                          : req_rs1_i;
          end else if (cache_hit) begin
            state_d = ST_RESP; set_rsp = 1'b1; data_d = cache_data;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (md_ready_i) begin
          state_d = ST_RESP; set_rsp = 1'b1; data_d = md_data_i;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_RESP; set_rsp = 1'b1; data_d = '0; err_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (flush_i || rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      inst_q  <= MD_NOP;
      rs1_q   <= '0;
      rs2_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ld_req) begin
        inst_q <= req_inst_i;
        rs1_q  <= req_rs1_i;
        rs2_q  <= req_rs2_i;
        tag_q  <= req_tag_i;
      end
      if (set_rsp) begin
        data_q <= data_d;
        err_q  <= err_d;
      end
      // Held at zero outside BUSY, so it is clear on every entry.
      wd_q <= (state_q == ST_BUSY) ? wd_q + 1'b1 : '0;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = data_q;
  assign rsp_tag_o   = tag_q;
  assign rsp_err_o   = err_q;
  assign md_inst_o   = (state_q == ST_BUSY) ? inst_q : MD_NOP;
  assign md_rs1_o    = (state_q == ST_BUSY) ? rs1_q : '0;
  assign md_rs2_o    = (state_q == ST_BUSY) ? rs2_q : '0;

endmodule
